// File: rtl/write_block.sv
// Write-back stage pipeline register: registers the data-memory stage result
// and presents it to the register-file write port one clock later.
module write_block #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:WIDTH-1] ans_dm,
  output logic [0:WIDTH-1] ans_wb
);

  // NOTE: sequential state uses non-blocking assignment so every register in
  // the pipeline samples its input from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ans_wb <= '0;
    end else begin
      ans_wb <= ans_dm;
    end
  end

endmodule

// File: tb/tb_write_block.sv
// Self-checking bench for write_block: directed reset/latency/bit-order cases
// followed by randomized data with random mid-cycle reset pulses.
module tb_write_block;

  localparam int WIDTH = 16;

  logic             clk;
  logic             reset;
  logic [0:WIDTH-1] ans_dm;
  logic [0:WIDTH-1] ans_wb;

  int checks = 0;
  int errors = 0;

  // Value the write-back port must hold: last value captured while out of reset.
  logic [0:WIDTH-1] expected;

  write_block #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .ans_dm(ans_dm),
    .ans_wb(ans_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [0:WIDTH-1] got,
                       input logic [0:WIDTH-1] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive a value at the falling edge, confirm the output holds until the
  // rising edge, then confirm the value appears just after it.
  task automatic load(input string tag, input logic [0:WIDTH-1] d);
    @(negedge clk);
    ans_dm = d;
    #3;
    check({tag, "_hold"}, ans_wb, expected);
    @(posedge clk);
    #1;
    expected = d;
    check({tag, "_load"}, ans_wb, expected);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:WIDTH-1] d;
    logic [0:WIDTH-1] d2;

    reset    = 1'b1;
    ans_dm   = 16'h0000;
    expected = '0;

    // Reset hold: input ignored, including unknown values.
    #1;
    check("reset_initial", ans_wb, 16'h0000);
    @(posedge clk); #1;
    check("reset_hold_0000", ans_wb, 16'h0000);
    ans_dm = 16'hFFFF;
    @(posedge clk); #1;
    check("reset_hold_ffff", ans_wb, 16'h0000);
    ans_dm = 'x;
    @(posedge clk); #1;
    check("reset_hold_x", ans_wb, 16'h0000);

    // Reset release away from an edge: no load until the next rising edge.
    @(negedge clk);
    ans_dm = 16'h0002;
    reset  = 1'b0;
    #2;
    check("release_before_edge", ans_wb, 16'h0000);
    @(posedge clk); #1;
    expected = 16'h0002;
    check("release_first_load", ans_wb, expected);

    // Pipeline latency.
    load("lat_1234", 16'h1234);
    load("lat_abcd", 16'hABCD);
    load("lat_8000", 16'h8000);
    check("bitorder_msb", {15'b0, ans_wb[0]}, 16'h0001);
    load("lat_0001", 16'h0001);
    check("bitorder_lsb", {15'b0, ans_wb[15]}, 16'h0001);

    // Asynchronous clear between edges, then reload of the current input.
    load("pre_clear", 16'hFFFF);
    #2;
    ans_dm = 16'h5A5A;
    reset  = 1'b1;
    #1;
    expected = '0;
    check("async_clear", ans_wb, expected);
    #1;
    reset = 1'b0;
    #1;
    check("clear_after_release", ans_wb, expected);
    @(posedge clk); #1;
    expected = 16'h5A5A;
    check("reload_after_clear", ans_wb, expected);

    // Mid-cycle input toggle: output moves only at the rising edge.
    @(negedge clk);
    ans_dm = 16'h0F0F;
    #1;
    check("toggle_a", ans_wb, expected);
    ans_dm = 16'hF0F0;
    #1;
    check("toggle_b", ans_wb, expected);
    ans_dm = 16'h3C3C;
    @(posedge clk); #1;
    expected = 16'h3C3C;
    check("toggle_load", ans_wb, expected);

    // Randomized data with occasional mid-cycle toggles and short reset pulses.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      d      = WIDTH'($urandom);
      ans_dm = d;
      if ($urandom_range(0, 7) == 0) begin
        #1;
        reset = 1'b1;
        #1;
        expected = '0;
        check("rand_pulse_clear", ans_wb, expected);
        #1;
        reset = 1'b0;
      end else begin
        #3;
      end
      if ($urandom_range(0, 3) == 0) begin
        d2     = WIDTH'($urandom);
        ans_dm = d2;
        d      = d2;
      end
      check("rand_hold", ans_wb, expected);
      @(posedge clk); #1;
      expected = d;
      check("rand_load", ans_wb, expected);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
